fram_bist_sequencer: RTL and testbench

- Upstream request generator for axis_master: drives its start / mem_address / data_in / write_enable / read_enable user interface and consumes busy / data_out.
- Performs a FRAM built-in self test.
  - Write pass: writes pattern addr^PATTERN_XOR to every word address in [ADDR_FIRST..ADDR_LAST].
  - Read pass: reads every word back and compares it with the pattern.
- Reports pass/fail, error count and first failing location; guards each transaction with a timeout.

---
 rtl/fram_bist_pkg.sv | 22 ++
 rtl/fram_bist_sequencer_if.sv | 22 ++
 rtl/bist_timeout_ctr.sv | 42 ++++
 rtl/fram_bist_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_fram_bist_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fram_bist_pkg.sv
// Shared types and sizing helpers for the FRAM built-in self-test sequencer.
package fram_bist_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_CHECK   = 3'd5,
    ST_FINISH  = 3'd6
  } state_e;

  // Bits needed to count up to the per-phase cycle limit.
  function automatic int tmo_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/fram_bist_sequencer_if.sv
// Request/response bundle between the BIST sequencer and axis_master.
interface fram_bist_sequencer_if;
  import fram_bist_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] data_in;
  logic              write_enable;
  logic              read_enable;
  logic              busy;
  logic [DATA_W-1:0] data_out;

  modport master (
    output start, mem_address, data_in, write_enable, read_enable,
    input  busy, data_out
  );

  modport slave (
    input  start, mem_address, data_in, write_enable, read_enable,
    output busy, data_out
  );
endinterface

// File: rtl/bist_timeout_ctr.sv
// Per-phase cycle counter: cleared on every handshake state entry, flags
// expiry once the phase has lasted LIMIT cycles.
module bist_timeout_ctr #(
  parameter int W     = 17,
  parameter int LIMIT = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST_CNT = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/fram_bist_sequencer.sv
// FRAM BIST sequencer: write pass of addr^PATTERN_XOR over the address range,
// read-back pass with compare, result reporting and per-phase timeout.
module fram_bist_sequencer
  import fram_bist_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_FIRST     = 8'h00,
  parameter logic [ADDR_W-1:0] ADDR_LAST      = 8'hFF,
  parameter logic [DATA_W-1:0] PATTERN_XOR    = 8'hA5,
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  fram_bist_sequencer_if.master    bus,
  output logic                     active_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [DATA_W-1:0]        err_count_o,
  output logic [ADDR_W-1:0]        fail_addr_o,
  output logic [DATA_W-1:0]        fail_data_o
);

  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] err_q, err_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic start_q, start_d, we_q, we_d, re_q, re_d;
  logic active_q, active_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic phase_en_s;
  logic expired_s;
  logic tmo_clr_s;

  assign phase_en_s = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  assign tmo_clr_s  = (state_d != state_q);

  bist_timeout_ctr #(.W(TMO_W), .LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr_s),
    .en_i      (phase_en_s),
    .expired_o (expired_s)
  );

  // Next-state and next-output logic; request outputs are set on the
  // transition into a REQ state so they are registered and stable.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    start_d  = start_q;
    we_d     = we_q;
    re_d     = re_q;
    active_d = active_q;
    done_d   = done_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          done_d   = 1'b0;
          pass_d   = 1'b0;
          tmo_d    = 1'b0;
          err_d    = 8'h00;
          faddr_d  = 8'h00;
          fdata_d  = 8'h00;
          addr_d   = ADDR_FIRST;
          din_d    = ADDR_FIRST ^ PATTERN_XOR;
          active_d = 1'b1;
          start_d  = 1'b1;
          we_d     = 1'b1;
          state_d  = ST_WR_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (bus.busy) begin
          start_d = 1'b0;
          we_d    = 1'b0;
          re_d    = 1'b0;
          state_d = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
        end else if (expired_s) begin
          tmo_d   = 1'b1;
          start_d = 1'b0;
          we_d    = 1'b0;
          re_d    = 1'b0;
          state_d = ST_FINISH;
        end else begin
          state_d = state_q;
        end
      end
      ST_WR_WAIT: begin
        if (!bus.busy) begin
          start_d = 1'b1;
          if (addr_q == ADDR_LAST) begin
            addr_d  = ADDR_FIRST;
            re_d    = 1'b1;
            state_d = ST_RD_REQ;
          end else begin
            addr_d  = addr_q + 8'd1;
            din_d   = (addr_q + 8'd1) ^ PATTERN_XOR;
            we_d    = 1'b1;
            state_d = ST_WR_REQ;
          end
        end else if (expired_s) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!bus.busy) begin
          rdata_d = bus.data_out;
          state_d = ST_CHECK;
        end else if (expired_s) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_CHECK: begin
        if (rdata_q != (addr_q ^ PATTERN_XOR)) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = err_q;
          end
          if (err_q == 8'h00) begin
            faddr_d = addr_q;
            fdata_d = rdata_q;
          end else begin
            faddr_d = faddr_q;
          end
        end else begin
          err_d = err_q;
        end
        if (addr_q == ADDR_LAST) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + 8'd1;
          start_d = 1'b1;
          re_d    = 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_FINISH: begin
        active_d = 1'b0;
        done_d   = 1'b1;
        pass_d   = (err_q == 8'h00) && !tmo_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        start_d  = 1'b0;
        we_d     = 1'b0;
        re_d     = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= 8'h00;
      din_q    <= 8'h00;
      rdata_q  <= 8'h00;
      err_q    <= 8'h00;
      faddr_q  <= 8'h00;
      fdata_q  <= 8'h00;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      faddr_q  <= faddr_d;
      fdata_q  <= fdata_d;
      start_q  <= start_d;
      we_q     <= we_d;
      re_q     <= re_d;
      active_q <= active_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.start        = start_q;
  assign bus.mem_address  = addr_q;
  assign bus.data_in      = din_q;
  assign bus.write_enable = we_q;
  assign bus.read_enable  = re_q;
  assign active_o         = active_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign timeout_o        = tmo_q;
  assign err_count_o      = err_q;
  assign fail_addr_o      = faddr_q;
  assign fail_data_o      = fdata_q;

endmodule

// File: tb/tb_fram_bist_sequencer.sv
// Bench for fram_bist_sequencer: two instances (range 0..3 and 0..FF) each
// driven by a behavioural axis_master model; transactions are scored against
// an expected queue built when each test is launched.
module tb_fram_bist_sequencer;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] run_s;
  logic [1:0] start_s, we_s, re_s, busy_m;
  logic [1:0] act_s, done_s, pass_s, tmo_s;
  logic [7:0] addr_s [2];
  logic [7:0] din_s [2];
  logic [7:0] dout_m [2];
  logic [7:0] err_s [2];
  logic [7:0] faddr_s [2];
  logic [7:0] fdata_s [2];
  int         mode [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam logic [7:0] LAST = (g == 0) ? 8'h03 : 8'hFF;
    fram_bist_sequencer_if bus ();
    assign bus.busy     = busy_m[g];
    assign bus.data_out = dout_m[g];
    assign start_s[g]   = bus.start;
    assign we_s[g]      = bus.write_enable;
    assign re_s[g]      = bus.read_enable;
    assign addr_s[g]    = bus.mem_address;
    assign din_s[g]     = bus.data_in;
    fram_bist_sequencer #(
      .ADDR_FIRST(8'h00), .ADDR_LAST(LAST), .PATTERN_XOR(8'hA5), .TIMEOUT_CYCLES(50)
    ) dut (
      .clk_i(clk), .rst_i(rst), .run_i(run_s[g]), .bus(bus),
      .active_o(act_s[g]), .done_o(done_s[g]), .pass_o(pass_s[g]),
      .timeout_o(tmo_s[g]), .err_count_o(err_s[g]),
      .fail_addr_o(faddr_s[g]), .fail_data_o(fdata_s[g])
    );
  end

  // axis_master model: busy rises 2 cycles after start, lasts 20 cycles.
  // mode 0 clean, 1 corrupt addr 0x02 on read, 2 all reads 0x00, 3 never busy.
  int         phase [2];
  int         cnt [2];
  logic [7:0] lat_addr [2];
  logic       lat_we [2];
  logic [7:0] mem [2][256];
  logic       log_we [2048];
  logic [7:0] log_addr [2048];
  logic [7:0] log_data [2048];
  int         log_n = 0;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        phase[g]  <= 0;
        cnt[g]    <= 0;
        busy_m[g] <= 1'b0;
        dout_m[g] <= 8'h00;
      end else begin
        case (phase[g])
          0: if (start_s[g] && mode[g] != 3) begin
            phase[g]    <= 1;
            cnt[g]      <= 0;
            lat_addr[g] <= addr_s[g];
            lat_we[g]   <= we_s[g];
            if (we_s[g]) mem[g][addr_s[g]] <= din_s[g];
            if (log_n < 2048) begin
              log_we[log_n]   <= we_s[g];
              log_addr[log_n] <= addr_s[g];
              log_data[log_n] <= we_s[g] ? din_s[g] : 8'h00;
              log_n           <= log_n + 1;
            end
          end
          1: if (cnt[g] == 1) begin
            busy_m[g] <= 1'b1;
            phase[g]  <= 2;
            cnt[g]    <= 0;
          end else begin
            cnt[g] <= cnt[g] + 1;
          end
          2: if (cnt[g] == 19) begin
            busy_m[g] <= 1'b0;
            phase[g]  <= 0;
            if (!lat_we[g]) begin
              if (mode[g] == 2 || (mode[g] == 1 && lat_addr[g] == 8'h02)) dout_m[g] <= 8'h00;
              else dout_m[g] <= mem[g][lat_addr[g]];
            end
          end else begin
            cnt[g] <= cnt[g] + 1;
          end
          default: phase[g] <= 0;
        endcase
      end
    end
  end

  txn_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected write pass then read pass over [first..last].
  task automatic push_pass(input logic [7:0] first, input logic [7:0] last);
    int n = int'(last) - int'(first) + 1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] a = first + 8'(i);
      exp_q.push_back({1'b1, a, a ^ 8'hA5});
    end
    for (int i = 0; i < n; i++) begin
      logic [7:0] a = first + 8'(i);
      exp_q.push_back({1'b0, a, 8'h00});
    end
  endtask

  // Pop every expected transaction and compare with what the model saw.
  task automatic check_log(input string tag, input int base);
    int idx = base;
    chk({tag, "_count"}, 32'(log_n - base), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      txn_t t = exp_q.pop_front();
      if (idx < log_n) chk({tag, "_txn"}, {15'd0, log_we[idx], log_addr[idx], log_data[idx]}, {15'd0, t});
      idx++;
    end
  endtask

  task automatic pulse_run(input int g);
    @(negedge clk);
    run_s[g] = 1'b1;
    @(negedge clk);
    run_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input string tag, output int cyc);
    cyc = 1;
    while (!done_s[g] && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, {31'd0, done_s[g]}, 32'd1);
  endtask

  initial begin
    int base;
    int cyc;
    rst = 1'b1;
    run_s = 2'b00;
    mode[0] = 0;
    mode[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_start", {31'd0, start_s[0]}, 32'd0);
    chk("rst_active", {31'd0, act_s[0]}, 32'd0);
    chk("rst_done", {31'd0, done_s[0]}, 32'd0);
    chk("rst_pass", {31'd0, pass_s[0]}, 32'd0);
    chk("rst_addr", {24'd0, addr_s[0]}, 32'd0);
    chk("rst_err", {24'd0, err_s[1]}, 32'd0);

    // Clean run over 0x00..0x03
    base = log_n;
    push_pass(8'h00, 8'h03);
    pulse_run(0);
    wait_done(0, "clean", cyc);
    chk("clean_pass", {31'd0, pass_s[0]}, 32'd1);
    chk("clean_err", {24'd0, err_s[0]}, 32'd0);
    chk("clean_tmo", {31'd0, tmo_s[0]}, 32'd0);
    chk("clean_active", {31'd0, act_s[0]}, 32'd0);
    check_log("clean", base);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("clean_idle_start", {31'd0, start_s[0]}, 32'd0);
    end
    chk("clean_done_held", {31'd0, done_s[0]}, 32'd1);

    // Fault injection at address 0x02
    mode[0] = 1;
    base = log_n;
    push_pass(8'h00, 8'h03);
    pulse_run(0);
    wait_done(0, "fault", cyc);
    chk("fault_err", {24'd0, err_s[0]}, 32'd1);
    chk("fault_addr", {24'd0, faddr_s[0]}, 32'h02);
    chk("fault_data", {24'd0, fdata_s[0]}, 32'h00);
    chk("fault_pass", {31'd0, pass_s[0]}, 32'd0);
    check_log("fault", base);

    // Full range, every read returns 0x00
    mode[1] = 2;
    base = log_n;
    push_pass(8'h00, 8'hFF);
    pulse_run(1);
    wait_done(1, "full", cyc);
    chk("full_err_sat", {24'd0, err_s[1]}, 32'hFF);
    chk("full_fail_addr", {24'd0, faddr_s[1]}, 32'h00);
    chk("full_fail_data", {24'd0, fdata_s[1]}, 32'h00);
    chk("full_pass", {31'd0, pass_s[1]}, 32'd0);
    chk("full_tmo", {31'd0, tmo_s[1]}, 32'd0);
    check_log("full", base);

    // Timeout: busy never rises
    mode[0] = 3;
    base = log_n;
    pulse_run(0);
    chk("tmo_start_req", {31'd0, start_s[0]}, 32'd1);
    wait_done(0, "tmo", cyc);
    chk("tmo_latency", {31'd0, (cyc >= 50 && cyc <= 54)}, 32'd1);
    chk("tmo_flag", {31'd0, tmo_s[0]}, 32'd1);
    chk("tmo_pass", {31'd0, pass_s[0]}, 32'd0);
    chk("tmo_start", {31'd0, start_s[0]}, 32'd0);
    chk("tmo_we", {31'd0, we_s[0]}, 32'd0);
    check_log("tmo", base);

    // Reset while the read of 0x01 is in flight
    mode[0] = 0;
    base = log_n;
    pulse_run(0);
    cyc = 0;
    while (!(log_n == base + 6 && busy_m[0]) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached", {31'd0, (log_n == base + 6 && busy_m[0] == 1'b1)}, 32'd1);
    if (log_n == base + 6) chk("mid_rd_addr", {24'd0, log_addr[base + 5]}, 32'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_start", {31'd0, start_s[0]}, 32'd0);
    chk("mid_re", {31'd0, re_s[0]}, 32'd0);
    chk("mid_active", {31'd0, act_s[0]}, 32'd0);
    chk("mid_addr", {24'd0, addr_s[0]}, 32'd0);
    chk("mid_done", {31'd0, done_s[0]}, 32'd0);
    base = log_n;
    push_pass(8'h00, 8'h03);
    pulse_run(0);
    wait_done(0, "rerun", cyc);
    chk("rerun_pass", {31'd0, pass_s[0]}, 32'd1);
    check_log("rerun", base);

    // Second run pulse while active is ignored
    base = log_n;
    push_pass(8'h00, 8'h03);
    pulse_run(0);
    repeat (30) @(negedge clk);
    chk("dup_active", {31'd0, act_s[0]}, 32'd1);
    pulse_run(0);
    wait_done(0, "dup", cyc);
    chk("dup_pass", {31'd0, pass_s[0]}, 32'd1);
    chk("dup_err", {24'd0, err_s[0]}, 32'd0);
    repeat (5) @(negedge clk);
    chk("dup_idle_start", {31'd0, start_s[0]}, 32'd0);
    check_log("dup", base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
